alu_issue_stage: RTL

ID/EX issue stage that produces ALU operands and ALU operation codes. It decodes a 32-bit RV32I instruction plus register-file read data into SrcA, SrcB and ALUControl for the integer ALU. Results are registered with a valid/ready handshake. It sits between the register-file read and the ALU, and supplies branch-resolution hints consumed alongside the ALU Zero flag.

---
 rtl/alu_issue_stage.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: ID/EX issue stage building SrcA/SrcB/ALUControl for the integer ALU.
// Optional macro ALU_ISSUE_SKID_EN adds a skid entry and makes in_ready registered.
module alu_issue_stage #(
    parameter int XLEN           = 32,
    parameter bit ILLEGAL_AS_NOP = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     Instr,
    input  logic [XLEN-1:0] PC,
    input  logic [XLEN-1:0] RD1,
    input  logic [XLEN-1:0] RD2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] SrcA,
    output logic [XLEN-1:0] SrcB,
    output logic [3:0]      ALUControl,
    output logic [XLEN-1:0] ImmOut,
    output logic [XLEN-1:0] PCOut,
    output logic [4:0]      Rd,
    output logic            RegWrite,
    output logic            Branch,
    output logic            BranchOnZero,
    output logic            IllegalInstr
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;

    typedef struct packed {
        logic [XLEN-1:0] src_a;
        logic [XLEN-1:0] src_b;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic [3:0]      alu_ctrl;
        logic [4:0]      rd;
        logic            reg_write;
        logic            branch;
        logic            br_on_zero;
        logic            illegal;
    } issue_t;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rd_f;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_b;
    logic            is_op;
    logic            is_opimm;
    logic            is_lui;
    logic            is_auipc;
    logic            is_branch;
    logic            legal;
    logic            unused_rs1;
    issue_t          dec;

    assign opcode = Instr[6:0];
    assign funct3 = Instr[14:12];
    assign funct7 = Instr[31:25];
    assign rd_f   = Instr[11:7];

    // rs1 arrives as RD1, so its index field is not needed here
    assign unused_rs1 = ^Instr[19:15];

    assign imm_i = {{(XLEN-12){Instr[31]}}, Instr[31:20]};
    assign imm_u = {Instr[31:12], 12'b0};
    assign imm_b = {{(XLEN-13){Instr[31]}}, Instr[31], Instr[7],
                    Instr[30:25], Instr[11:8], 1'b0};

    assign is_op     = (opcode == OPC_OP);
    assign is_opimm  = (opcode == OPC_OPIMM);
    assign is_lui    = (opcode == OPC_LUI);
    assign is_auipc  = (opcode == OPC_AUIPC);
    assign is_branch = (opcode == OPC_BRANCH);

    // Decode the incoming instruction into an issue payload
    always_comb begin
        dec   = '0;
        legal = 1'b0;
        unique case (1'b1)
            is_op: begin
                legal = (funct7 == F7_ZERO) ||
                        ((funct7 == F7_ALT) &&
                         ((funct3 == 3'b000) || (funct3 == 3'b101)));
                dec.src_a     = RD1;
                dec.src_b     = RD2;
                dec.alu_ctrl  = {Instr[30], funct3};
                dec.rd        = rd_f;
                dec.reg_write = 1'b1;
            end
            is_opimm: begin
                if (funct3 == 3'b001) begin
                    legal = (funct7 == F7_ZERO);
                end else if (funct3 == 3'b101) begin
                    legal = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
                end else begin
                    legal = 1'b1;
                end
                dec.src_a     = RD1;
                dec.src_b     = imm_i;
                dec.imm       = imm_i;
                dec.alu_ctrl  = {(funct3 == 3'b101) & Instr[30], funct3};
                dec.rd        = rd_f;
                dec.reg_write = 1'b1;
            end
            is_lui: begin
                legal         = 1'b1;
                dec.src_a     = '0;
                dec.src_b     = imm_u;
                dec.imm       = imm_u;
                dec.alu_ctrl  = ALU_ADD;
                dec.rd        = rd_f;
                dec.reg_write = 1'b1;
            end
            is_auipc: begin
                legal         = 1'b1;
                dec.src_a     = PC;
                dec.src_b     = imm_u;
                dec.imm       = imm_u;
                dec.alu_ctrl  = ALU_ADD;
                dec.rd        = rd_f;
                dec.reg_write = 1'b1;
            end
            is_branch: begin
                legal          = (funct3[2:1] != 2'b01);
                dec.src_a      = RD1;
                dec.src_b      = RD2;
                dec.imm        = imm_b;
                dec.branch     = 1'b1;
                dec.alu_ctrl   = funct3[2] ? {3'b001, funct3[1]} : ALU_SUB;
                dec.br_on_zero = ~(funct3[2] ^ funct3[0]);
            end
            default: begin
                legal = 1'b0;
            end
        endcase
        dec.pc = PC;
        if (!legal) begin
            dec         = '0;
            dec.pc      = PC;
            dec.illegal = 1'b1;
        end
        if (dec.rd == 5'd0) begin
            dec.reg_write = 1'b0;
        end
    end

    logic   take;
    logic   issue;
    logic   out_valid_q;
    logic   out_valid_d;
    issue_t out_q;
    issue_t out_d;

    assign take  = in_valid && in_ready && !flush;
    assign issue = take && (ILLEGAL_AS_NOP || !dec.illegal);

`ifdef ALU_ISSUE_SKID_EN
    logic   skid_valid_q;
    logic   skid_valid_d;
    issue_t skid_q;
    issue_t skid_d;

    assign in_ready = !skid_valid_q;

    // Two-entry queue: output slot refills from skid first to keep order
    always_comb begin
        out_valid_d  = out_valid_q;
        out_d        = out_q;
        skid_valid_d = skid_valid_q;
        skid_d       = skid_q;
        if (!out_valid_q || out_ready) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_d        = skid_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = issue;
                if (issue) begin
                    out_d = dec;
                end
            end
        end else if (issue) begin
            skid_valid_d = 1'b1;
            skid_d       = dec;
        end
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end
    end

    // Skid entry registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_valid_q <= 1'b0;
            skid_q       <= '0;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_q       <= skid_d;
        end
    end
`else
    assign in_ready = flush || !out_valid_q || out_ready;

    // Single entry: a capture replaces the accepted entry with no bubble
    always_comb begin
        out_valid_d = out_valid_q;
        out_d       = out_q;
        if (out_ready) begin
            out_valid_d = 1'b0;
        end
        if (issue) begin
            out_valid_d = 1'b1;
            out_d       = dec;
        end
        if (flush) begin
            out_valid_d = 1'b0;
        end
    end
`endif

    // Output entry registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign SrcA         = out_q.src_a;
    assign SrcB         = out_q.src_b;
    assign ALUControl   = out_q.alu_ctrl;
    assign ImmOut       = out_q.imm;
    assign PCOut        = out_q.pc;
    assign Rd           = out_q.rd;
    assign RegWrite     = out_q.reg_write;
    assign Branch       = out_q.branch;
    assign BranchOnZero = out_q.br_on_zero;
    assign IllegalInstr = out_q.illegal;

endmodule
